// File: rtl/fetch_stage_if.sv
// Instruction-memory channel of the fetch stage: valid/ready request, valid-only response.
`timescale 1ns/1ps
interface fetch_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch with a 2-entry response queue feeding the IF/ID register.
// Handles decode stalls and EX redirects; at most one memory request is outstanding.
`timescale 1ns/1ps
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_stage_if.master       imem,
  input  logic                redirect_valid_i,
  input  logic [31:0]         redirect_pc_i,
  input  logic                stall_i,
  output logic                id_valid_o,
  output logic [31:0]         id_inst_o,
  output logic [31:0]         id_pc_o
);

  typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic        drop_q;
  logic [31:0] qpc_q   [2];
  logic [31:0] qinst_q [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;
  logic        id_valid_q;
  logic [31:0] id_inst_q;
  logic [31:0] id_pc_q;

  logic req_valid;
  logic req_fire;
  logic rsp_take;
  logic rsp_keep;
  logic bypass;
  logic push;
  logic pop;

  // Issue only with guaranteed queue space so a returning response never overflows.
  assign req_valid = rst_n && (state_q == S_REQ) && !redirect_valid_i && (cnt_q != 2'd2);
  assign req_fire  = req_valid && imem.req_ready;
  assign rsp_take  = (state_q == S_WAIT) && imem.rsp_valid;
  assign rsp_keep  = rsp_take && !drop_q && !redirect_valid_i;
  assign bypass    = rsp_keep && (cnt_q == 2'd0) && !stall_i;
  assign push      = rsp_keep && !bypass;
  assign pop       = !stall_i && !redirect_valid_i && (cnt_q != 2'd0);

  assign imem.req_valid = req_valid;
  assign imem.req_addr  = pc_q;
  assign id_valid_o     = id_valid_q;
  assign id_inst_o      = id_inst_q;
  assign id_pc_o        = id_pc_q;

  always_comb begin
    cnt_d = cnt_q;
    if (redirect_valid_i)   cnt_d = 2'd0;
    else if (push && !pop)  cnt_d = cnt_q + 2'd1;
    else if (pop && !push)  cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qpc_q[wr_ptr_q]   <= req_pc_q;
      qinst_q[wr_ptr_q] <= imem.rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      drop_q     <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      id_valid_q <= 1'b0;
      id_inst_q  <= NOP_INST;
      id_pc_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (redirect_valid_i) begin
        pc_q       <= redirect_pc_i;
        rd_ptr_q   <= 1'b0;
        wr_ptr_q   <= 1'b0;
        id_valid_q <= 1'b0;
        id_inst_q  <= NOP_INST;
        // An in-flight request still returns; mark it so it is thrown away on arrival.
        if (state_q == S_WAIT) begin
          if (imem.rsp_valid) begin
            state_q <= S_REQ;
            drop_q  <= 1'b0;
          end else begin
            drop_q  <= 1'b1;
          end
        end
      end else begin
        if (req_fire) begin
          req_pc_q <= pc_q;
          pc_q     <= pc_q + 32'd4;
          state_q  <= S_WAIT;
        end
        if (rsp_take) begin
          state_q <= S_REQ;
          drop_q  <= 1'b0;
        end
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
        if (!stall_i) begin
          if (pop) begin
            id_valid_q <= 1'b1;
            id_inst_q  <= qinst_q[rd_ptr_q];
            id_pc_q    <= qpc_q[rd_ptr_q];
          end else if (bypass) begin
            id_valid_q <= 1'b1;
            id_inst_q  <= imem.rsp_data;
            id_pc_q    <= req_pc_q;
          end else begin
            id_valid_q <= 1'b0;
            id_inst_q  <= NOP_INST;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder plus a transaction-level model of the fetch stream.
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .imem             (imem),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .stall_i          (stall),
    .id_valid_o       (id_valid),
    .id_inst_o        (id_inst),
    .id_pc_o          (id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory responder state
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_lat;
  int          lat_fix;
  bit          lat_rand;

  // Reference model: next fetch address, in-flight request, fetched-not-consumed FIFO, IF/ID view
  logic [31:0] m_pc;
  bit          m_out;
  bit          m_stale;
  logic [31:0] m_out_pc;
  logic [31:0] m_qpc[$];
  logic [31:0] m_qinst[$];
  bit          m_id_valid;
  logic [31:0] m_id_inst;
  logic [31:0] m_id_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_C0DE;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_out = 0; m_stale = 0; m_out_pc = '0;
    m_qpc.delete(); m_qinst.delete();
    m_id_valid = 0; m_id_inst = NOP_INST; m_id_pc = '0;
    mem_pend = 0; mem_addr = '0; mem_lat = 0;
  endtask

  // One clock: caller has set stall/redirect/ready; called at posedge+1.
  task automatic step();
    bit          exp_rv, rsp, dut_fire;
    logic [31:0] dut_addr, rdata;
    rsp   = mem_pend && (mem_lat == 0);
    rdata = rsp ? mem_word(mem_addr) : 32'h0;
    imem.rsp_valid = rsp;
    imem.rsp_data  = rdata;
    #1;
    exp_rv = !m_out && !redirect_valid && (m_qpc.size() < 2);
    chk("req_valid", {31'b0, imem.req_valid}, {31'b0, exp_rv});
    if (exp_rv) chk("req_addr", imem.req_addr, m_pc);
    dut_fire = imem.req_valid && imem.req_ready;
    dut_addr = imem.req_addr;

    if (rsp && m_out) begin
      if (!m_stale && !redirect_valid) begin
        m_qpc.push_back(m_out_pc);
        m_qinst.push_back(rdata);
      end
      m_out = 0; m_stale = 0;
    end
    if (redirect_valid) begin
      m_qpc.delete(); m_qinst.delete();
      if (m_out) m_stale = 1;
      m_pc = redirect_pc;
      m_id_valid = 0; m_id_inst = NOP_INST;
    end else begin
      if (exp_rv && imem.req_ready) begin
        m_out = 1; m_out_pc = m_pc; m_pc = m_pc + 32'd4;
      end
      if (!stall) begin
        if (m_qpc.size() != 0) begin
          m_id_valid = 1;
          m_id_pc    = m_qpc.pop_front();
          m_id_inst  = m_qinst.pop_front();
        end else begin
          m_id_valid = 0; m_id_inst = NOP_INST;
        end
      end
    end

    if (mem_pend) begin
      if (mem_lat == 0) mem_pend = 0;
      else mem_lat--;
    end
    if (dut_fire) begin
      mem_pend = 1; mem_addr = dut_addr;
      mem_lat  = lat_rand ? int'($urandom_range(0, 3)) : lat_fix;
    end

    @(posedge clk); #1;
    chk("id_valid", {31'b0, id_valid}, {31'b0, m_id_valid});
    chk("id_inst", id_inst, m_id_inst);
    if (m_id_valid) chk("id_pc", id_pc, m_id_pc);
  endtask

  initial begin
    bit found;
    redirect_valid = 0; redirect_pc = '0; stall = 0;
    imem.req_ready = 1; imem.rsp_valid = 0; imem.rsp_data = '0;
    lat_fix = 0; lat_rand = 0;
    model_reset();
    rst_n = 1;
    #2 rst_n = 0;
    #2;
    chk("rst_req_valid", {31'b0, imem.req_valid}, 32'd0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_inst", id_inst, NOP_INST);
    chk("rst_id_pc", id_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Streaming with 1-cycle memory latency
    repeat (10) step();

    // Memory back-pressure
    imem.req_ready = 0;
    repeat (3) step();
    imem.req_ready = 1;
    repeat (6) step();

    // Decode stall long enough to fill the queue, then release
    stall = 1;
    repeat (6) step();
    stall = 0;
    repeat (8) step();

    // Redirect while a request is in flight, its response 2 cycles later
    lat_fix = 2;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (mem_pend && mem_lat == 2) found = 1;
    end
    chk("reach_wait", {31'b0, found}, 32'd1);
    redirect_valid = 1; redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 0;
    lat_fix = 0;
    repeat (10) step();

    // Redirect together with stall while the queue is full
    stall = 1;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (m_qpc.size() == 2) found = 1;
    end
    chk("queue_full", {31'b0, found}, 32'd1);
    redirect_valid = 1; redirect_pc = 32'h0000_0200;
    step();
    redirect_valid = 0;
    step();
    stall = 0;
    repeat (8) step();

    // Address wrap at the top of memory
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 0;
    repeat (10) step();

    // Randomized traffic
    lat_rand = 1;
    for (int i = 0; i < 400; i++) begin
      imem.req_ready = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
      step();
    end
    redirect_valid = 0; stall = 0; imem.req_ready = 1;
    lat_rand = 0; lat_fix = 1;
    repeat (8) step();

    // Asynchronous reset while waiting for a response
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (m_out) found = 1;
    end
    chk("reach_wait2", {31'b0, found}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("arst_req_valid", {31'b0, imem.req_valid}, 32'd0);
    chk("arst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("arst_id_inst", id_inst, NOP_INST);
    chk("arst_id_pc", id_pc, 32'h0);
    model_reset();
    imem.rsp_valid = 0;
    @(posedge clk); #1 rst_n = 1;
    lat_fix = 0;
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
